// File: rtl/thresh_mon8.sv
// thresh_mon8: streaming threshold monitor with hysteresis and persistence.
// Ports: clk/rst (async high), thr_we/thr_hi_in/thr_lo_in threshold load,
// n_persist run length, d_valid/d_in sample in; level/rise/fall/cnt/ev_cnt out.
module thresh_mon8 #(
  parameter int CNT_W = 4,
  parameter int EV_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             thr_we,
  input  logic [7:0]       thr_hi_in,
  input  logic [7:0]       thr_lo_in,
  input  logic [CNT_W-1:0] n_persist,
  input  logic             d_valid,
  input  logic [7:0]       d_in,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt,
  output logic [EV_W-1:0]  ev_cnt
);

  localparam logic [0:0] BELOW = 1'b0;
  localparam logic [0:0] ABOVE = 1'b1;

  logic [0:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [EV_W-1:0]  ev_q, ev_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;

  logic [CNT_W:0]   npe;
  logic [CNT_W:0]   cnt_inc;
  logic             qual;

  // A zero run length behaves like one.
  assign npe = (n_persist == '0) ? (CNT_W+1)'(1)
                                 : {1'b0, n_persist};
  // One extra bit so the increment never wraps.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Only the threshold facing away from the current level matters.
  assign qual = d_valid &&
                ((level_q == ABOVE) ? (d_in < lo_q)
                                    : (d_in > hi_q));

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    ev_d    = ev_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (thr_we) begin
      // Threshold load wins over any sample in the same cycle.
      hi_d  = thr_hi_in;
      lo_d  = thr_lo_in;
      cnt_d = '0;
    end else if (d_valid) begin
      if (!qual) begin
        cnt_d = '0;
      end else if (cnt_inc < npe) begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end else begin
        cnt_d = '0;
        if (level_q == BELOW) begin
          level_d = ABOVE;
          rise_d  = 1'b1;
          if (ev_q != '1) ev_d = ev_q + 1'b1;
        end else begin
          level_d = BELOW;
          fall_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= BELOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ev_q    <= '0;
      hi_q    <= 8'hFF;
      lo_q    <= 8'h00;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ev_q    <= ev_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign level  = level_q[0];
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign cnt    = cnt_q;
  assign ev_cnt = ev_q;

endmodule

// File: tb/tb_thresh_mon8.sv
// tb_thresh_mon8: directed and random checks of thresh_mon8
// against a behavioural model; a narrow-counter copy covers saturation.
module tb_thresh_mon8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       thr_we = 1'b0;
  logic [7:0] thr_hi_in = '0;
  logic [7:0] thr_lo_in = '0;
  logic [3:0] n_persist = '0;
  logic       d_valid = 1'b0;
  logic [7:0] d_in = '0;

  logic        level, rise, fall;
  logic [3:0]  cnt;
  logic [15:0] ev_cnt;

  logic        level_s, rise_s, fall_s;
  logic [3:0]  cnt_s;
  logic [5:0]  ev_cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  int m_level, m_cnt, m_ev, m_ev_s, m_hi, m_lo;
  int m_rise, m_fall;

  thresh_mon8 #(.CNT_W(4), .EV_W(16)) dut (
    .clk(clk), .rst(rst), .thr_we(thr_we),
    .thr_hi_in(thr_hi_in), .thr_lo_in(thr_lo_in),
    .n_persist(n_persist), .d_valid(d_valid), .d_in(d_in),
    .level(level), .rise(rise), .fall(fall),
    .cnt(cnt), .ev_cnt(ev_cnt)
  );

  thresh_mon8 #(.CNT_W(4), .EV_W(6)) dut_s (
    .clk(clk), .rst(rst), .thr_we(thr_we),
    .thr_hi_in(thr_hi_in), .thr_lo_in(thr_lo_in),
    .n_persist(n_persist), .d_valid(d_valid), .d_in(d_in),
    .level(level_s), .rise(rise_s), .fall(fall_s),
    .cnt(cnt_s), .ev_cnt(ev_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".level"}, {31'd0, level}, m_level);
    chk({tag, ".rise"}, {31'd0, rise}, m_rise);
    chk({tag, ".fall"}, {31'd0, fall}, m_fall);
    chk({tag, ".cnt"}, {28'd0, cnt}, m_cnt);
    chk({tag, ".ev"}, {16'd0, ev_cnt}, m_ev);
    chk({tag, ".ev_s"}, {26'd0, ev_cnt_s}, m_ev_s);
    chk({tag, ".rise_s"}, {31'd0, rise_s}, m_rise);
  endtask

  task automatic model_reset();
    m_level = 0; m_cnt = 0; m_ev = 0; m_ev_s = 0;
    m_hi = 255; m_lo = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare.
  task automatic step(input string tag, input bit v, input int d,
                      input bit we, input int hi, input int lo,
                      input int np);
    int npe;
    bit q;
    d_valid = v; d_in = 8'(d); thr_we = we;
    thr_hi_in = 8'(hi); thr_lo_in = 8'(lo);
    n_persist = 4'(np);
    @(posedge clk);
    npe = (np == 0) ? 1 : np;
    m_rise = 0; m_fall = 0;
    if (we) begin
      m_hi = hi; m_lo = lo; m_cnt = 0;
    end else if (v) begin
      q = (m_level == 1) ? (d < m_lo) : (d > m_hi);
      if (!q) m_cnt = 0;
      else if (m_cnt + 1 >= npe) begin
        m_cnt = 0;
        m_level = 1 - m_level;
        if (m_level == 1) begin
          m_rise = 1;
          if (m_ev < 65535) m_ev++;
          if (m_ev_s < 63) m_ev_s++;
        end else m_fall = 1;
      end else m_cnt++;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic smp(input string tag, input int d, input int np);
    step(tag, 1'b1, d, 1'b0, 0, 0, np);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("reset");

    for (int i = 0; i < 20; i++) smp("ff_idle", 255, 0);
    chk("ff_level", {31'd0, level}, 0);

    step("prog", 1'b0, 0, 1'b1, 100, 50, 3);
    smp("p1", 101, 3);
    smp("p2", 101, 3);
    smp("p3", 101, 3);
    chk("persist_rise", {31'd0, rise}, 1);
    chk("persist_ev", {16'd0, ev_cnt}, 1);

    smp("h50", 50, 3);
    smp("h49a", 49, 3);
    step("hgap", 1'b0, 49, 1'b0, 0, 0, 3);
    smp("h49b", 49, 3);
    smp("h49c", 49, 3);
    chk("hyst_fall", {31'd0, fall}, 1);

    smp("i150a", 150, 3);
    smp("i150b", 150, 3);
    smp("i100", 100, 3);
    smp("i150c", 150, 3);
    smp("i150d", 150, 3);
    chk("interrupt_cnt", {28'd0, cnt}, 2);

    step("collide", 1'b1, 200, 1'b1, 120, 40, 3);
    chk("collide_cnt", {28'd0, cnt}, 0);
    smp("post110", 110, 3);
    smp("post121", 121, 3);

    // lowering n_persist below cnt forces the next qualifier through
    smp("np_a", 130, 5);
    smp("np_b", 130, 5);
    smp("np_c", 130, 1);

    for (int i = 0; i < 400; i++) begin
      bit we;
      we = ($urandom_range(0, 9) == 0);
      step("rand", 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)), we,
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)));
    end

    step("sat_prog", 1'b0, 0, 1'b1, 100, 50, 1);
    for (int i = 0; i < 70; i++) begin
      smp("sat_hi", 200, 1);
      smp("sat_lo", 10, 1);
    end
    smp("sat_last", 200, 1);
    chk("sat_ev_s", {26'd0, ev_cnt_s}, 32'h3F);
    chk("sat_rise_s", {31'd0, rise_s}, 1);

    step("pre_rst", 1'b0, 0, 1'b1, 100, 50, 4);
    smp("pre_a", 20, 4);
    smp("pre_b", 20, 4);
    #3;
    do_reset("mid_reset");
    smp("after_rst", 255, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
